alu_operand_arbiter: RTL

- Round-robin arbiter that shares one 32-bit datapath port among 8 requesters.
- Registers the 3-bit select that drives the downstream 8:1 32-bit operand mux.
- Forwards the granted requester's beats through a valid/ready handshake.
- Holds the grant for a burst, which ends on last, a beat cap or an idle timeout, then rotates priority.

---
 rtl/alu_operand_arbiter_if.sv | 26 ++
 rtl/alu_operand_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/alu_operand_arbiter_if.sv
// Handshake and operand-bus bundle between 8 requesters, the arbiter and the datapath.
interface alu_operand_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [7:0]          req_valid;
  logic [7:0]          req_last;
  logic [8*DATA_W-1:0] req_data;
  logic [7:0]          req_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [2:0]          out_src;
  logic                out_ready;
  logic [2:0]          sel;
  logic                busy;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, sel, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, sel, busy
  );
endinterface

// File: rtl/alu_operand_arbiter.sv
// Round-robin 8:1 arbiter for a shared 32-bit operand port; 1-cycle arbitration, bursts held until last/cap/idle timeout.
// Downstream out_ready stalls the granted requester indefinitely without timing out.
module alu_operand_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int IDLE_TO   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_operand_arbiter_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state;
  logic [2:0]        sel;
  logic [2:0]        ptr;
  logic [4:0]        beat_cnt;
  logic [7:0]        idle_cnt;

  logic [2:0]        winner;
  logic [2:0]        idx;
  logic              any_req;
  logic              grant;
  logic              granted_vld;
  logic [DATA_W-1:0] granted_dat;
  logic              burst_cap;
  logic              xfer;
  logic              timeout;

  // Descending scan so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    idx     = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (bus.req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign grant       = (state == ST_GRANT);
  assign granted_vld = bus.req_valid[sel];
  assign granted_dat = bus.req_data[int'(sel)*DATA_W +: DATA_W];
  assign burst_cap   = (beat_cnt == 5'(MAX_BURST - 1));

  assign bus.out_valid = grant & granted_vld;
  assign bus.out_data  = grant ? granted_dat : '0;
  assign bus.out_last  = grant & (bus.req_last[sel] | burst_cap);
  assign bus.req_ready = (grant & bus.out_ready) ? (8'b1 << sel) : 8'b0;
  assign bus.out_src   = sel;
  assign bus.sel       = sel;
  assign bus.busy      = grant;

  assign xfer    = bus.out_valid & bus.out_ready;
  assign timeout = grant & ~granted_vld & (idle_cnt == 8'(IDLE_TO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= 3'd0;
      ptr      <= 3'd0;
      beat_cnt <= 5'd0;
      idle_cnt <= 8'd0;
    end else if (state == ST_IDLE) begin
      if (any_req) begin
        sel      <= winner;
        beat_cnt <= 5'd0;
        idle_cnt <= 8'd0;
        state    <= ST_GRANT;
      end
    end else begin
      if (xfer) begin
        beat_cnt <= beat_cnt + 5'd1;
      end
      // Stalled beats count as activity, so backpressure never trips the timeout.
      if (granted_vld) begin
        idle_cnt <= 8'd0;
      end else if (!timeout) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      if ((xfer && bus.out_last) || timeout) begin
        ptr   <= sel + 3'd1;
        state <= ST_IDLE;
      end
    end
  end
endmodule
